sig_pulse_gen: RTL and testbench

SIG_PULSE_GEN -- requirements
Module: sig_pulse_gen

---
 rtl/sig_gen_pkg.sv | 15 +
 rtl/cyc_counter.sv | 35 +++
 rtl/sig_pulse_gen.sv | 165 ++++++++++++++++
 tb/tb_sig_pulse_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sig_gen_pkg.sv
// sig_gen_pkg: shared types and defaults for the pulse-train generator.
// Holds the FSM state enum and the default count-field width.
package sig_gen_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_e;

endpackage

// File: rtl/cyc_counter.sv
// cyc_counter: loadable CNT_W-bit down-counter that stops at zero.
// Ports: clk, rst_n (sync, active-low), load_i, val_i in; zero_o out.
module cyc_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign zero_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (!zero_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sig_pulse_gen.sv
// sig_pulse_gen: registered pulse-train generator (delay, high, low, repeat).
// In: clk, rst_n, start, abort, delay/high/low_cyc, repeat_cnt.
// Out: sig_a, busy, done, cfg_err, pulse_idx (all registered).
module sig_pulse_gen
  import sig_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_cyc,
  input  logic [CNT_W-1:0] high_cyc,
  input  logic [CNT_W-1:0] low_cyc,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             sig_a,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] pulse_idx
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  logic sig_a_q, busy_q, done_q;
  logic cfg_err_q, cfg_err_d;

  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic             cnt_zero;

  logic [CNT_W-1:0] low_eff;
  logic [CNT_W-1:0] rep_eff;
  logic [CNT_W:0]   idx_nxt;

  // Zero gap and zero repeat both behave as one.
  assign low_eff = (low_q == '0) ? CNT_W'(1) : low_q;
  assign rep_eff = (rep_q == '0) ? CNT_W'(1) : rep_q;
  // One bit wider so the compare never wraps.
  assign idx_nxt = {1'b0, idx_q} + 1'b1;

  cyc_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .val_i  (ld_val),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    high_d    = high_q;
    low_d     = low_q;
    rep_d     = rep_q;
    idx_d     = idx_q;
    cfg_err_d = 1'b0;
    ld        = 1'b0;
    ld_val    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (high_cyc == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            high_d = high_cyc;
            low_d  = low_cyc;
            rep_d  = repeat_cnt;
            idx_d  = '0;
            ld     = 1'b1;
            if (delay_cyc != '0) begin
              state_d = S_DELAY;
              ld_val  = delay_cyc - 1'b1;
            end else begin
              state_d = S_HIGH;
              ld_val  = high_cyc - 1'b1;
            end
          end
        end
      end
      S_DELAY: begin
        if (cnt_zero) begin
          state_d = S_HIGH;
          ld      = 1'b1;
          ld_val  = high_q - 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_zero) begin
          idx_d = idx_nxt[CNT_W-1:0];
          if (idx_nxt < {1'b0, rep_eff}) begin
            state_d = S_LOW;
            ld      = 1'b1;
            ld_val  = low_eff - 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOW: begin
        if (cnt_zero) begin
          state_d = S_HIGH;
          ld      = 1'b1;
          ld_val  = high_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a start in IDLE.
    if (abort) begin
      state_d   = S_IDLE;
      idx_d     = idx_q;
      high_d    = high_q;
      low_d     = low_q;
      rep_d     = rep_q;
      cfg_err_d = 1'b0;
      ld        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      high_q    <= '0;
      low_q     <= '0;
      rep_q     <= '0;
      idx_q     <= '0;
      sig_a_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      high_q    <= high_d;
      low_q     <= low_d;
      rep_q     <= rep_d;
      idx_q     <= idx_d;
      sig_a_q   <= (state_d == S_HIGH);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      cfg_err_q <= cfg_err_d;
    end
  end

  assign sig_a     = sig_a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign pulse_idx = idx_q;

endmodule

// File: tb/tb_sig_pulse_gen.sv
// tb_sig_pulse_gen: random + directed stimulus against a timeline model.
// The model predicts every output per cycle from train start arithmetic.
module tb_sig_pulse_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] delay_cyc;
  logic [7:0] high_cyc;
  logic [7:0] low_cyc;
  logic [7:0] repeat_cnt;
  logic       sig_a;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic [7:0] pulse_idx;

  sig_pulse_gen #(
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .delay_cyc  (delay_cyc),
    .high_cyc   (high_cyc),
    .low_cyc    (low_cyc),
    .repeat_cnt (repeat_cnt),
    .sig_a      (sig_a),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .pulse_idx  (pulse_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: cycle index of the outputs currently visible.
  int cyc = 0;
  bit act = 0;
  bit ecfg = 0;
  int t0, md, mh, ml, mr, end_c;
  int idx_hold = 0;

  int run_len = 0;

  always @(posedge clk) run_len <= sig_a ? run_len + 1 : 0;

  a_busy: assert property (@(posedge clk)
    $fell(busy) |-> $past(done || abort || !rst_n))
    else $error("FAIL a_busy: busy fell without cause at cycle %0d", cyc);

  a_run: assert property (@(posedge clk)
    ($fell(sig_a) && $past(rst_n) && !$past(abort)) |-> (run_len == mh))
    else $error("FAIL a_run: run %0d required %0d", run_len, mh);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int idx_at(int c);
    int k;
    int n;
    k = c - t0 - 1 - md;
    if (k < mh) return 0;
    n = (k - mh) / (mh + ml) + 1;
    return (n < mr) ? n : mr;
  endfunction

  task automatic step(bit st, bit ab, bit rn,
                      int d, int h, int l, int r);
    int k;
    int p;
    bit e_sig;
    bit e_busy;
    bit e_done;
    int e_idx;
    start      = st;
    abort      = ab;
    rst_n      = rn;
    delay_cyc  = 8'(d);
    high_cyc   = 8'(h);
    low_cyc    = 8'(l);
    repeat_cnt = 8'(r);
    @(posedge clk);
    ecfg = 0;
    if (!rn) begin
      act      = 0;
      idx_hold = 0;
    end else if (act) begin
      if (ab || cyc == end_c) begin
        idx_hold = idx_at(cyc);
        act      = 0;
      end
    end else if (st && !ab) begin
      if (h == 0) begin
        ecfg = 1;
      end else begin
        act   = 1;
        t0    = cyc;
        md    = d;
        mh    = h;
        ml    = (l == 0) ? 1 : l;
        mr    = (r == 0) ? 1 : r;
        end_c = t0 + 1 + md + mr * mh + (mr - 1) * ml;
      end
    end
    cyc++;
    #1;
    if (act) begin
      k      = cyc - t0 - 1 - md;
      p      = mh + ml;
      e_sig  = (k >= 0) && (k / p < mr) && (k % p < mh);
      e_busy = 1;
      e_done = (cyc == end_c);
      e_idx  = idx_at(cyc);
    end else begin
      e_sig  = 0;
      e_busy = 0;
      e_done = 0;
      e_idx  = idx_hold;
    end
    check("sig_a", 32'(sig_a), 32'(e_sig));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("cfg_err", 32'(cfg_err), 32'(ecfg));
    check("pulse_idx", 32'(pulse_idx), 32'(e_idx));
  endtask

  // Idle cycles with scrambled config to show it is ignored.
  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255));
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_idx", 32'(pulse_idx), 32'd0);

    // Basic three-pulse train.
    step(1, 0, 1, 3, 2, 4, 3);
    idle(20);
    check("train_idx", 32'(pulse_idx), 32'd3);

    // Zero delay, single pulse, zero repeat.
    step(1, 0, 1, 0, 1, 7, 0);
    idle(4);

    // Zero high rejected.
    step(1, 0, 1, 2, 0, 2, 2);
    idle(2);

    // Abort during the second HIGH.
    step(1, 0, 1, 0, 2, 2, 3);
    idle(4);
    step(0, 1, 1, 0, 0, 0, 0);
    check("abort_idx", 32'(pulse_idx), 32'd1);
    idle(3);

    // Reset during LOW, then restart.
    step(1, 0, 1, 3, 2, 4, 3);
    idle(6);
    step(0, 0, 0, 9, 9, 9, 9);
    check("rst_busy", 32'(busy), 32'd0);
    step(1, 0, 1, 3, 2, 4, 3);
    idle(20);

    // Abort and start together in IDLE.
    step(1, 1, 1, 1, 1, 1, 1);
    idle(2);

    // Abort in DONE keeps the done pulse.
    step(1, 0, 1, 0, 1, 0, 1);
    idle(1);
    step(0, 1, 1, 0, 0, 0, 0);
    idle(2);

    // Start while busy is ignored; low=0 acts as one.
    step(1, 0, 1, 1, 1, 0, 3);
    step(1, 0, 1, 0, 3, 3, 3);
    idle(8);

    // Full-scale counts.
    step(1, 0, 1, 0, 255, 0, 1);
    idle(258);
    step(1, 0, 1, 255, 1, 255, 2);
    idle(515);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 199) != 0,
           $urandom_range(0, 5),
           $urandom_range(0, 4),
           $urandom_range(0, 4),
           $urandom_range(0, 4));
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
